// File: rtl/burst_sched_if.sv
// burst_sched_if: request/grant bundle between requesters and burst_sched.
//   req      requester -> sched : per-requester level request
//   run_len  requester -> sched : burst length, sampled on the grant decision
//   gnt      sched -> requester : one-hot grant during RUN
//   owner    sched -> requester : index of current/last granted requester
//   busy     sched -> engine    : engine enable (RUN)
//   last     sched -> engine    : one-cycle end-of-burst marker
//   tog      sched -> engine    : flips once per finished burst
interface burst_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int OWN_W = 2
);
  logic [N_REQ-1:0] req;
  logic [CNT_W-1:0] run_len;
  logic [N_REQ-1:0] gnt;
  logic [OWN_W-1:0] owner;
  logic             busy;
  logic             last;
  logic             tog;

  modport master (output req, run_len, input gnt, owner, busy, last, tog);
  modport slave  (input req, run_len, output gnt, owner, busy, last, tog);
endinterface

// File: rtl/burst_sched.sv
// burst_sched: round-robin scheduler sharing one burst engine between N_REQ
// requesters. IDLE picks a winner, RUN holds the grant for len cycles (or until
// the owner drops its request), LAST is a single closing cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    burst_sched_if.slave (req/run_len in; gnt/owner/busy/last/tog out)
//
// All outputs are flops loaded from the next-state decode, so gnt/busy/last
// line up with the state the FSM is entering.
//
// Build option BURST_SCHED_PRIO_EN: req[0] becomes a fixed high-priority
// requester; the others rotate over indices 1..N_REQ-1.
module burst_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int OWN_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  burst_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             tog_q, tog_d;

  logic [OWN_W-1:0] win;
  logic             owner_req;

  // Winner = set bit with the smallest rotated distance from the pointer.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] p);
    logic [OWN_W-1:0] w;
    int best_d, d, base;
    w      = '0;
    best_d = N_REQ;
`ifdef BURST_SCHED_PRIO_EN
    // ptr lives in 1..N_REQ-1 here; reset value 0 means "start at 1".
    base = (p == '0) ? 1 : int'(p);
    for (int k = 1; k < N_REQ; k++) begin
      d = (k - base + (N_REQ - 1)) % (N_REQ - 1);
      if (r[k] && d < best_d) begin
        best_d = d;
        w      = OWN_W'(k);
      end
    end
    if (r[0]) w = '0;
`else
    base = int'(p);
    for (int k = 0; k < N_REQ; k++) begin
      d = (k - base + N_REQ) % N_REQ;
      if (r[k] && d < best_d) begin
        best_d = d;
        w      = OWN_W'(k);
      end
    end
`endif
    return w;
  endfunction

  assign win       = rr_pick(bus.req, ptr_q);
  assign owner_req = bus.req[owner_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          owner_d = win;
          len_d   = (bus.run_len == '0) ? CNT_W'(1) : bus.run_len;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // len >= 1, so len-1 never underflows; cnt tops out at len, no wrap.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == len_q - CNT_W'(1) || !owner_req) state_d = S_LAST;
      end
      S_LAST: begin
`ifdef BURST_SCHED_PRIO_EN
        // A priority burst leaves the rotation untouched.
        if (owner_q != '0)
          ptr_d = (owner_q == OWN_W'(N_REQ - 1)) ? OWN_W'(1) : owner_q + OWN_W'(1);
`else
        ptr_d = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    last_d = (state_d == S_LAST);
    tog_d  = tog_q ^ last_d;
    gnt_d  = '0;
    for (int i = 0; i < N_REQ; i++)
      gnt_d[i] = busy_d && (owner_d == OWN_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      tog_q   <= tog_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.last  = last_q;
  assign bus.tog   = tog_q;

endmodule

// File: tb/tb_burst_sched.sv
// tb_burst_sched: directed bench for burst_sched. Each step pushes the bursts
// it expects (owner, gnt length, gnt-low gap before it) onto a scoreboard; a
// negedge monitor measures every burst and pops/compares on the last pulse.
module tb_burst_sched;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int OWN_W = 2;

  typedef struct {
    int owner;
    int len;
    int gap;   // expected gnt-low cycles before this burst, -1 = don't care
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  exp_t sb[$];

  burst_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W), .OWN_W(OWN_W)) bif ();

  burst_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .OWN_W(OWN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int o, input int l, input int g);
    exp_t e;
    e.owner = o; e.len = l; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_last(input int budget);
    int k;
    bit seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (bif.last === 1'b1) seen = 1'b1;
      k++;
    end
    if (!seen) check("timeout_last", 0, 1);
  endtask

  task automatic wait_busy(input int budget);
    int k;
    bit seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (bif.busy === 1'b1) seen = 1'b1;
      k++;
    end
    if (!seen) check("timeout_busy", 0, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bif.req = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Burst monitor / scoreboard consumer.
  int         run_cnt, low_cnt, cur_owner;
  logic       exp_tog, prev_busy, prev_last;
  exp_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_cnt = 0; low_cnt = 0; exp_tog = 1'b0;
      prev_busy = 1'b0; prev_last = 1'b0;
    end else begin
      if (bif.busy === 1'b1) begin
        if (!prev_busy) begin
          if (sb.size() == 0) check("unexpected_burst", 1, 0);
          else if (sb[0].gap >= 0) check("gap", low_cnt, sb[0].gap);
          run_cnt   = 0;
          cur_owner = int'(bif.owner);
        end
        run_cnt++;
        low_cnt = 0;
        check("gnt_onehot", {28'd0, bif.gnt}, 32'd1 << bif.owner);
        check("owner_stable", {30'd0, bif.owner}, cur_owner);
      end else begin
        low_cnt++;
        check("gnt_idle", {28'd0, bif.gnt}, 0);
      end
      if (bif.last === 1'b1) begin
        exp_tog = ~exp_tog;
        check("last_1cyc", {31'd0, prev_last}, 0);
        check("last_busy", {31'd0, bif.busy}, 0);
        check("tog", {31'd0, bif.tog}, {31'd0, exp_tog});
        if (sb.size() == 0) check("unexpected_last", 1, 0);
        else begin
          got = sb.pop_front();
          check("burst_owner", {30'd0, bif.owner}, got.owner);
          check("burst_len", run_cnt, got.len);
        end
      end
      prev_busy = bif.busy;
      prev_last = bif.last;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bif.req     = '0;
    bif.run_len = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt",   {28'd0, bif.gnt}, 0);
    check("rst_busy",  {31'd0, bif.busy}, 0);
    check("rst_last",  {31'd0, bif.last}, 0);
    check("rst_tog",   {31'd0, bif.tog}, 0);
    check("rst_owner", {30'd0, bif.owner}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single requester, 5-cycle burst
    push_exp(1, 5, -1);
    bif.req = 4'b0010; bif.run_len = 4'd5;
    wait_last(20);
    check("t1_tog",   {31'd0, bif.tog}, 1);
    check("t1_owner", {30'd0, bif.owner}, 1);
    @(posedge clk); #1 bif.req = '0;
    @(negedge clk);
    check("t1_idle_busy", {31'd0, bif.busy}, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with 2-cycle gaps
    reset_dut();
    push_exp(0, 3, -1); push_exp(1, 3, 2); push_exp(2, 3, 2);
    push_exp(3, 3, 2);  push_exp(0, 3, 2);
    bif.req = 4'b1111; bif.run_len = 4'd3;
    for (int i = 0; i < 5; i++) wait_last(20);
    @(posedge clk); #1 bif.req = '0;

    // 3: abort after 3 gnt cycles
    reset_dut();
    push_exp(2, 3, -1);
    bif.req = 4'b0100; bif.run_len = 4'd8;
    wait_busy(20);
    repeat (2) @(posedge clk);
    #1 bif.req = '0;
    wait_last(10);
    @(negedge clk);
    check("t3_idle_busy", {31'd0, bif.busy}, 0);
    check("t3_idle_last", {31'd0, bif.last}, 0);

    // 4: run_len 0 -> 1 cycle; run_len 15 -> 15 cycles, later run_len edits ignored
    reset_dut();
    push_exp(0, 1, -1); push_exp(0, 15, 2);
    bif.req = 4'b0001; bif.run_len = 4'd0;
    wait_last(10);
    @(posedge clk); #1 bif.run_len = 4'd15;
    wait_busy(10);
    @(posedge clk); #1 bif.run_len = 4'd2;
    wait_last(30);
    @(posedge clk); #1 bif.req = '0;

    // 5: async reset mid-RUN, then owner 0 first
    reset_dut();
    push_exp(1, 8, -1);
    bif.req = 4'b0010; bif.run_len = 4'd8;
    wait_busy(10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    bif.req = 4'b1111; bif.run_len = 4'd2;
    #1;
    check("t5_gnt",   {28'd0, bif.gnt}, 0);
    check("t5_busy",  {31'd0, bif.busy}, 0);
    check("t5_last",  {31'd0, bif.last}, 0);
    check("t5_tog",   {31'd0, bif.tog}, 0);
    check("t5_owner", {30'd0, bif.owner}, 0);
    sb.delete();
    push_exp(0, 2, -1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_last(10);
    @(posedge clk); #1 bif.req = '0;

    // 6: req[0] arrives during owner-1 burst
    reset_dut();
    bif.run_len = 4'd2;
`ifdef BURST_SCHED_PRIO_EN
    push_exp(1, 2, -1); push_exp(0, 2, 2); push_exp(2, 2, 2);
    bif.req = 4'b1110;
    wait_busy(10);
    @(posedge clk); #1 bif.req = 4'b1111;
    wait_last(10);
    wait_last(10);
    @(posedge clk); #1 bif.req = 4'b1110;
    wait_last(10);
`else
    push_exp(1, 2, -1); push_exp(2, 2, 2);
    bif.req = 4'b1110;
    wait_busy(10);
    @(posedge clk); #1 bif.req = 4'b1111;
    wait_last(10);
    wait_last(10);
`endif
    @(posedge clk); #1 bif.req = '0;

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
